// File: rtl/gpu_mem_combine_sched.sv
// Frame scheduler for the half-word combine datapath: loads one frame of payload and weight
// words from two independent streams, then emits the combined words serially.
module gpu_mem_combine_sched #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int FCNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       abort,
    input  logic                       pay_valid,
    output logic                       pay_ready,
    input  logic [DATA_W-1:0]          pay_data,
    input  logic                       wgt_valid,
    output logic                       wgt_ready,
    input  logic [DATA_W-1:0]          wgt_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(2*LANES)-1:0] out_index,
    output logic                       out_last,
    output logic                       busy,
    output logic [FCNT_W-1:0]          frame_cnt
);

    localparam int H      = DATA_W / 2;
    localparam int WORDS  = 2 * LANES;
    localparam int PIDX_W = $clog2(LANES);
    localparam int WIDX_W = $clog2(WORDS);

    localparam logic [PIDX_W:0]   PAY_FULL = LANES[PIDX_W:0];
    localparam logic [WIDX_W:0]   WGT_FULL = WORDS[WIDX_W:0];
    localparam logic [WIDX_W-1:0] IDX_LAST = WIDX_W'(WORDS - 1);

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    state_t              state, state_d;
    logic [PIDX_W:0]     pay_cnt, pay_cnt_d;
    logic [WIDX_W:0]     wgt_cnt, wgt_cnt_d;
    logic [WIDX_W-1:0]   emit_idx, emit_idx_d;
    logic [FCNT_W-1:0]   frame_cnt_d;

    logic [DATA_W-1:0]   pay_buf [LANES];
    logic [DATA_W-1:0]   wgt_buf [WORDS];

    logic                pay_acc;
    logic                wgt_acc;

    // Weight high half on top; payload high half for even slots, low half for odd slots.
    function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] pay_word,
                                                  input logic [DATA_W-1:0] wgt_word,
                                                  input logic              odd);
        return {wgt_word[DATA_W-1:H], odd ? pay_word[H-1:0] : pay_word[DATA_W-1:H]};
    endfunction

    assign pay_ready = (state == LOAD) && (pay_cnt < PAY_FULL);
    assign wgt_ready = (state == LOAD) && (wgt_cnt < WGT_FULL);
    assign pay_acc   = pay_valid && pay_ready;
    assign wgt_acc   = wgt_valid && wgt_ready;

    assign out_valid = (state == EMIT);
    assign out_index = emit_idx;
    assign out_last  = out_valid && (emit_idx == IDX_LAST);
    assign out_data  = combine(pay_buf[emit_idx[WIDX_W-1:1]], wgt_buf[emit_idx], emit_idx[0]);
    assign busy      = out_valid || (pay_cnt != '0) || (wgt_cnt != '0);

    always_comb begin
        state_d     = state;
        pay_cnt_d   = pay_cnt;
        wgt_cnt_d   = wgt_cnt;
        emit_idx_d  = emit_idx;
        frame_cnt_d = frame_cnt;
        case (state)
            LOAD: begin
                if (abort) begin
                    pay_cnt_d = '0;
                    wgt_cnt_d = '0;
                end else begin
                    if (pay_acc) pay_cnt_d = pay_cnt + 1'b1;
                    if (wgt_acc) wgt_cnt_d = wgt_cnt + 1'b1;
                    if ((pay_cnt_d == PAY_FULL) && (wgt_cnt_d == WGT_FULL)) state_d = EMIT;
                end
            end
            EMIT: begin
                // Abort wins over a coinciding final handshake, so the frame is not counted.
                if (abort) begin
                    state_d    = LOAD;
                    pay_cnt_d  = '0;
                    wgt_cnt_d  = '0;
                    emit_idx_d = '0;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_d     = LOAD;
                        pay_cnt_d   = '0;
                        wgt_cnt_d   = '0;
                        emit_idx_d  = '0;
                        frame_cnt_d = frame_cnt + 1'b1;
                    end else begin
                        emit_idx_d = emit_idx + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LOAD;
            pay_cnt   <= '0;
            wgt_cnt   <= '0;
            emit_idx  <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            pay_cnt   <= pay_cnt_d;
            wgt_cnt   <= wgt_cnt_d;
            emit_idx  <= emit_idx_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    // Frame buffers carry data only; they are never reset and are rewritten every frame.
    always_ff @(posedge clock) begin
        if (pay_acc) pay_buf[pay_cnt[PIDX_W-1:0]] <= pay_data;
        if (wgt_acc) wgt_buf[wgt_cnt[WIDX_W-1:0]] <= wgt_data;
    end

endmodule

// File: tb/tb_gpu_mem_combine_sched.sv
// Directed/randomized bench for gpu_mem_combine_sched with a frame-level reference model.
module tb_gpu_mem_combine_sched;

    localparam int LANES  = 8;
    localparam int DATA_W = 32;
    localparam int FCNT_W = 2;
    localparam int NW     = 2 * LANES;
    localparam int IW     = $clog2(NW);

    logic              clock = 1'b0;
    logic              reset, abort;
    logic              pay_valid, pay_ready, wgt_valid, wgt_ready;
    logic [DATA_W-1:0] pay_data, wgt_data, out_data;
    logic              out_valid, out_ready, out_last, busy;
    logic [IW-1:0]     out_index;
    logic [FCNT_W-1:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int model_frames = 0;
    logic [DATA_W-1:0] fpay [LANES];
    logic [DATA_W-1:0] fwgt [NW];
    logic [DATA_W-1:0] got0, got1;

    gpu_mem_combine_sched #(.LANES(LANES), .DATA_W(DATA_W), .FCNT_W(FCNT_W)) dut (
        .clock(clock), .reset(reset), .abort(abort),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output word j: weight j high half above either the high (even j) or low (odd j) half of payload j/2.
    function automatic logic [DATA_W-1:0] exp_word(input int j);
        int unsigned hi, lo;
        hi = fwgt[j] / 65536;
        if (j % 2 == 1) lo = fpay[j/2] % 65536;
        else            lo = fpay[j/2] / 65536;
        return hi * 65536 + lo;
    endfunction

    task automatic new_data();
        for (int i = 0; i < LANES; i++) fpay[i] = $urandom;
        for (int i = 0; i < NW; i++)    fwgt[i] = $urandom;
    endtask

    // Feeds beats until pay_lim/wgt_lim are accepted; returns one cycle after the final handshake.
    task automatic load_frame(input int pay_lim, input int wgt_lim, input int pay_first, input int wgt_period);
        int pi, wi, cyc, wph;
        pi = 0; wi = 0; cyc = 0; wph = 0;
        while (!(pi == pay_lim && wi == wgt_lim) && cyc < 500) begin
            pay_valid = (pi < pay_lim) || (pay_first != 0);
            pay_data  = (pi < LANES) ? fpay[pi] : 32'hDEADBEEF;
            wgt_valid = (wi < wgt_lim) && (pay_first == 0 || pi == LANES) && (wph % wgt_period == 0);
            wgt_data  = (wi < NW) ? fwgt[wi] : 32'h0;
            if (pay_first == 0 || pi == LANES) wph++;
            @(negedge clock);
            check("load_pay_ready", 64'(pay_ready), 64'(pi < LANES));
            check("load_wgt_ready", 64'(wgt_ready), 64'(wi < NW));
            check("load_out_valid", 64'(out_valid), 64'(0));
            check("load_busy", 64'(busy), 64'(pi > 0 || wi > 0));
            if (pay_valid && pay_ready) pi++;
            if (wgt_valid && wgt_ready) wi++;
            @(posedge clock); #1;
            cyc++;
        end
        check("load_done", 64'(pi == pay_lim && wi == wgt_lim), 64'(1));
        pay_valid = 1'b0;
        wgt_valid = 1'b0;
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random. stop_kind: 0 none, 1 abort, 2 reset at stop_idx.
    task automatic emit_frame(input int rmode, input int stop_idx, input int stop_kind);
        int ei, cyc;
        logic done;
        ei = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stop_kind != 0 && ei == stop_idx) begin
                out_ready = 1'b1;
                if (stop_kind == 1) abort = 1'b1;
                else                reset = 1'b1;
            end
            @(negedge clock);
            check("emit_valid", 64'(out_valid), 64'(1));
            check("emit_index", 64'(out_index), 64'(ei));
            check("emit_last", 64'(out_last), 64'(ei == NW - 1));
            check("emit_data", 64'(out_data), 64'(exp_word(ei)));
            check("emit_pay_ready", 64'(pay_ready), 64'(0));
            check("emit_wgt_ready", 64'(wgt_ready), 64'(0));
            check("emit_busy", 64'(busy), 64'(1));
            if (out_ready && ei == 0) got0 = out_data;
            if (out_ready && ei == 1) got1 = out_data;
            if (stop_kind != 0 && ei == stop_idx) done = 1'b1;
            else if (out_ready) begin
                ei++;
                if (ei == NW) done = 1'b1;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check("emit_done", 64'(done), 64'(1));
        abort = 1'b0;
        reset = 1'b0;
        out_ready = 1'b0;
        if (stop_kind == 0) model_frames++;
        if (stop_kind == 2) model_frames = 0;
        @(negedge clock);
        check("post_out_valid", 64'(out_valid), 64'(0));
        check("post_frame_cnt", 64'(frame_cnt), 64'(model_frames % (1 << FCNT_W)));
        check("post_busy", 64'(busy), 64'(0));
        check("post_pay_ready", 64'(pay_ready), 64'(1));
        check("post_wgt_ready", 64'(wgt_ready), 64'(1));
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; out_ready = 1'b0;
        pay_valid = 1'b0; wgt_valid = 1'b0; pay_data = '0; wgt_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_index", 64'(out_index), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_pay_ready", 64'(pay_ready), 64'(1));
        check("rst_wgt_ready", 64'(wgt_ready), 64'(1));
        @(posedge clock); #1;

        // basic frame with the documented corner words
        new_data();
        fpay[0] = 32'hAAAA5555; fwgt[0] = 32'h12340000; fwgt[1] = 32'h5678FFFF;
        load_frame(LANES, NW, 0, 1);
        emit_frame(0, 0, 0);
        check("basic_out0", 64'(got0), 64'h1234AAAA);
        check("basic_out1", 64'(got1), 64'h56785555);

        // payload first, weights one beat every third cycle
        new_data();
        load_frame(LANES, NW, 1, 3);
        emit_frame(0, 0, 0);

        // backpressure pattern and random readiness
        new_data();
        load_frame(LANES, NW, 0, 1);
        emit_frame(1, 0, 0);
        new_data();
        load_frame(LANES, NW, 0, 2);
        emit_frame(2, 0, 0);

        // abort mid-load, then a full fresh frame
        new_data();
        load_frame(5, 9, 0, 1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        check("abort_load_busy", 64'(busy), 64'(0));
        check("abort_load_pay_ready", 64'(pay_ready), 64'(1));
        @(posedge clock); #1;
        new_data();
        load_frame(LANES, NW, 0, 1);
        emit_frame(0, 0, 0);

        // abort during emit at index 7, then a normal frame
        new_data();
        load_frame(LANES, NW, 0, 1);
        emit_frame(0, 7, 1);
        new_data();
        load_frame(LANES, NW, 0, 1);
        emit_frame(2, 0, 0);

        // reset during emit at index 3
        new_data();
        load_frame(LANES, NW, 0, 1);
        emit_frame(0, 3, 2);

        // five back-to-back frames: frame_cnt 1,2,3,0,1
        for (int f = 0; f < 5; f++) begin
            new_data();
            load_frame(LANES, NW, 0, 1);
            emit_frame(0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
